// File: rtl/one_unit_mat_ser.sv
// ============================================================================
// one_unit_mat_ser : captures a 4x4 matrix and streams its 16 elements.
// Revision 1.0
// ============================================================================
`default_nettype none

module one_unit_mat_ser #(
   parameter int W         = 26,
   parameter int COL_MAJOR = 0,
   parameter int STALL_W   = 16
) (
   input  logic                clk_ser,
   input  logic                rst_n,
   input  logic                ld_valid,
   output logic                ld_ready,
   input  logic [16*W-1:0]     ld_mat,
   input  logic [1:0]          ld_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [W-1:0]        out_data,
   output logic [1:0]          out_row,
   output logic [1:0]          out_col,
   output logic                out_last,
   output logic [1:0]          out_tag,
   output logic                busy,
   output logic [STALL_W-1:0]  stall_cnt,
   input  logic                stall_clr
);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } state_t;

   localparam logic [STALL_W-1:0] C_STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

   state_t               state_q, state_d;
   logic [16*W-1:0]      cap_q, cap_d;
   logic [1:0]           tag_q, tag_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [STALL_W-1:0]   stall_q, stall_d;

   logic [1:0]           w_row, w_col;
   logic                 w_fire, w_load;
   logic [W-1:0]         w_elem [16];

   generate
      for (genvar e = 0; e < 16; e++) begin : g_elem
         assign w_elem[e] = cap_q[e*W +: W];
      end
      // The counter walks emission order; row/col always name the true position.
      if (COL_MAJOR != 0) begin : g_colmaj
         assign w_col = cnt_q[3:2];
         assign w_row = cnt_q[1:0];
      end else begin : g_rowmaj
         assign w_row = cnt_q[3:2];
         assign w_col = cnt_q[1:0];
      end
   endgenerate

   assign out_valid = (state_q == S_STREAM);
   assign busy      = (state_q == S_STREAM);
   assign out_last  = out_valid && (cnt_q == 4'd15);
   assign w_fire    = out_valid && out_ready;
   assign ld_ready  = (state_q == S_IDLE) || (w_fire && out_last);
   assign w_load    = ld_valid && ld_ready;

   assign out_data  = w_elem[{w_row, w_col}];
   assign out_row   = w_row;
   assign out_col   = w_col;
   assign out_tag   = tag_q;
   assign stall_cnt = stall_q;

   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      tag_d   = tag_q;
      cnt_d   = cnt_q;
      stall_d = stall_q;

      // A load in the last-element handshake cycle chains matrices with no bubble.
      if (w_load) begin
         cap_d   = ld_mat;
         tag_d   = ld_tag;
         cnt_d   = 4'd0;
         state_d = S_STREAM;
      end else if (w_fire) begin
         if (out_last) begin
            cnt_d   = 4'd0;
            state_d = S_IDLE;
         end else begin
            cnt_d   = cnt_q + 4'd1;
         end
      end

      if (stall_clr) begin
         stall_d = '0;
      end else if (out_valid && !out_ready && (stall_q != {STALL_W{1'b1}})) begin
         stall_d = stall_q + C_STALL_ONE;
      end
   end

   always_ff @(posedge clk_ser or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cap_q   <= '0;
         tag_q   <= 2'd0;
         cnt_q   <= 4'd0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
         tag_q   <= tag_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_one_unit_mat_ser.sv
// ============================================================================
// tb_one_unit_mat_ser : scoreboard bench for row-major, column-major and
// narrow-stall-counter builds of one_unit_mat_ser driven in lockstep.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_one_unit_mat_ser;

   localparam int W = 26;

   logic            clk;
   logic            rst_n;
   logic            ld_valid;
   logic [16*W-1:0] ld_mat;
   logic [1:0]      ld_tag;
   logic            out_ready;
   logic            stall_clr;

   logic [2:0]      ld_rdy, ov, ol, bsy;
   logic [W-1:0]    od   [3];
   logic [1:0]      orow [3];
   logic [1:0]      ocol [3];
   logic [1:0]      otag [3];
   logic [15:0]     sc0, sc1;
   logic [3:0]      sc2;

   int tests = 0;
   int fails = 0;

   logic [32:0] q0 [$];
   logic [32:0] q1 [$];
   logic [32:0] q2 [$];

   logic [16*W-1:0] mat_a, mat_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   one_unit_mat_ser #(.W(W), .COL_MAJOR(0), .STALL_W(16)) u0 (
      .clk_ser(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_rdy[0]),
      .ld_mat(ld_mat), .ld_tag(ld_tag), .out_valid(ov[0]), .out_ready(out_ready),
      .out_data(od[0]), .out_row(orow[0]), .out_col(ocol[0]), .out_last(ol[0]),
      .out_tag(otag[0]), .busy(bsy[0]), .stall_cnt(sc0), .stall_clr(stall_clr));

   one_unit_mat_ser #(.W(W), .COL_MAJOR(1), .STALL_W(16)) u1 (
      .clk_ser(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_rdy[1]),
      .ld_mat(ld_mat), .ld_tag(ld_tag), .out_valid(ov[1]), .out_ready(out_ready),
      .out_data(od[1]), .out_row(orow[1]), .out_col(ocol[1]), .out_last(ol[1]),
      .out_tag(otag[1]), .busy(bsy[1]), .stall_cnt(sc1), .stall_clr(stall_clr));

   one_unit_mat_ser #(.W(W), .COL_MAJOR(0), .STALL_W(4)) u2 (
      .clk_ser(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_rdy[2]),
      .ld_mat(ld_mat), .ld_tag(ld_tag), .out_valid(ov[2]), .out_ready(out_ready),
      .out_data(od[2]), .out_row(orow[2]), .out_col(ocol[2]), .out_last(ol[2]),
      .out_tag(otag[2]), .busy(bsy[2]), .stall_cnt(sc2), .stall_clr(stall_clr));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected stream for one matrix: row-major for u0/u2, column-major for u1.
   task automatic push_mat(input logic [16*W-1:0] m, input logic [1:0] tag);
      for (int i = 0; i < 16; i++) begin
         int r, c;
         logic [32:0] e;
         r = i / 4; c = i % 4;
         e = {m[(r*4+c)*W +: W], 2'(r), 2'(c), (i == 15), tag};
         q0.push_back(e);
         q2.push_back(e);
         r = i % 4; c = i / 4;
         e = {m[(r*4+c)*W +: W], 2'(r), 2'(c), (i == 15), tag};
         q1.push_back(e);
      end
   endtask

   task automatic pop_check(input int k, input logic [32:0] act);
      logic [32:0] e;
      logic        empty;
      empty = 1'b0;
      e = '0;
      case (k)
         0: if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
         1: if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
         default: if (q2.size() == 0) empty = 1'b1; else e = q2.pop_front();
      endcase
      if (empty) begin
         tests++;
         fails++;
         $display("FAIL u%0d unexpected element: got %0h expected none", k, act);
      end else begin
         chk($sformatf("u%0d element {data,row,col,last,tag}", k), 64'(act), 64'(e));
      end
   endtask

   logic [32:0] prev0;
   logic        prev_stall0 = 1'b0;

   // Monitor: mid-cycle, each presented element that will be taken is scored.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall0 = 1'b0;
      end else begin
         if (prev_stall0 && ov[0])
            chk("u0 hold during stall", 64'({od[0], orow[0], ocol[0], ol[0], otag[0]}), 64'(prev0));
         for (int k = 0; k < 3; k++) begin
            if (ov[k] && out_ready)
               pop_check(k, {od[k], orow[k], ocol[k], ol[k], otag[k]});
         end
         prev_stall0 = ov[0] && !out_ready;
         prev0       = {od[0], orow[0], ocol[0], ol[0], otag[0]};
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; ld_valid = 1'b0; ld_mat = '0; ld_tag = 2'd0;
      out_ready = 1'b1; stall_clr = 1'b0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            mat_a[(r*4+c)*W +: W] = W'((r+1)*16 + (c+1));
      mat_b = '1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset out_valid", 64'(ov), 64'(0));
      chk("reset busy", 64'(bsy), 64'(0));
      chk("reset out_last", 64'(ol), 64'(0));
      chk("reset out_data", 64'(od[0]), 64'(0));
      chk("reset row/col/tag", 64'({orow[0], ocol[0], otag[0]}), 64'(0));
      chk("reset stall_cnt", 64'({sc0, sc2}), 64'(0));
      #2 rst_n = 1'b1;
      tick();

      // Basic row/column-major stream, out_ready always 1
      chk("ld_ready idle", 64'(ld_rdy), 64'(3'b111));
      ld_valid = 1'b1; ld_mat = mat_a; ld_tag = 2'd2;
      push_mat(mat_a, 2'd2);
      chk("out_valid before accept", 64'(ov), 64'(0));
      tick();
      ld_valid = 1'b0;
      chk("out_valid 1 cycle after accept", 64'(ov), 64'(3'b111));
      chk("u0 first element", 64'(od[0]), 64'(17));
      chk("u1 first element", 64'(od[1]), 64'(17));
      repeat (3) tick();
      chk("u0 element 3", 64'(od[0]), 64'(20));
      chk("u1 element 3", 64'(od[1]), 64'(65));
      repeat (13) tick();
      chk("out_valid after last", 64'(ov), 64'(0));
      chk("busy after last", 64'(bsy), 64'(0));

      // Backpressure: out_ready 1,0,0,1,0,0,...
      ld_valid = 1'b1; ld_mat = mat_a; ld_tag = 2'd1;
      push_mat(mat_a, 2'd1);
      tick();
      ld_valid = 1'b0;
      for (int j = 0; j < 46; j++) begin
         out_ready = (j % 3 == 0);
         tick();
      end
      out_ready = 1'b1;
      chk("out_valid after stalled stream", 64'(ov), 64'(0));
      chk("u0 stall_cnt", 64'(sc0), 64'(30));
      chk("u1 stall_cnt", 64'(sc1), 64'(30));
      chk("u2 stall_cnt saturated", 64'(sc2), 64'(15));
      stall_clr = 1'b1;
      tick();
      stall_clr = 1'b0;
      chk("stall_cnt cleared", 64'({sc0, sc1, sc2}), 64'(0));

      // Back-to-back: B waits on ld_valid while A streams
      ld_valid = 1'b1; ld_mat = mat_a; ld_tag = 2'd0;
      push_mat(mat_a, 2'd0);
      tick();
      ld_mat = mat_b; ld_tag = 2'd3;
      push_mat(mat_b, 2'd3);
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("ld_ready during stream k=%0d", k), 64'(ld_rdy), (k == 15) ? 64'(3'b111) : 64'(0));
         tick();
      end
      ld_valid = 1'b0;
      chk("no bubble out_valid", 64'(ov), 64'(3'b111));
      chk("B element 0 sign intact", 64'(od[0]), 64'(26'h3FFFFFF));
      chk("B tag", 64'(otag[1]), 64'(3));
      repeat (16) tick();
      chk("idle after B", 64'(ov), 64'(0));

      // Asynchronous reset mid-stream
      ld_valid = 1'b1; ld_mat = mat_a; ld_tag = 2'd2;
      push_mat(mat_a, 2'd2);
      tick();
      ld_valid = 1'b0;
      repeat (8) tick();
      out_ready = 1'b0;
      repeat (2) tick();
      chk("stall_cnt before reset", 64'(sc0), 64'(2));
      #2 rst_n = 1'b0;
      #1;
      chk("async reset out_valid", 64'(ov), 64'(0));
      chk("async reset busy", 64'(bsy), 64'(0));
      chk("async reset stall_cnt", 64'({sc0, sc2}), 64'(0));
      q0.delete(); q1.delete(); q2.delete();
      out_ready = 1'b1;
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      chk("ld_ready after reset", 64'(ld_rdy), 64'(3'b111));
      repeat (2) tick();
      chk("no stale output", 64'(ov), 64'(0));
      ld_valid = 1'b1; ld_mat = mat_a; ld_tag = 2'd1;
      push_mat(mat_a, 2'd1);
      tick();
      ld_valid = 1'b0;
      chk("fresh load element 0", 64'(od[0]), 64'(17));
      repeat (16) tick();
      chk("idle after fresh stream", 64'(ov), 64'(0));

      // Saturation with 20 stalled cycles
      out_ready = 1'b0;
      ld_valid = 1'b1; ld_mat = mat_a; ld_tag = 2'd3;
      push_mat(mat_a, 2'd3);
      tick();
      ld_valid = 1'b0;
      repeat (20) tick();
      chk("u2 stall_cnt saturates", 64'(sc2), 64'(15));
      chk("u0 stall_cnt 20", 64'(sc0), 64'(20));
      chk("out_data held at element 0", 64'({od[0], od[1], od[2]}), 64'({26'd17, 26'd17, 26'd17}));
      out_ready = 1'b1;
      repeat (16) tick();
      chk("idle after saturation stream", 64'(ov), 64'(0));

      repeat (2) tick();
      chk("u0 scoreboard drained", 64'(q0.size()), 64'(0));
      chk("u1 scoreboard drained", 64'(q1.size()), 64'(0));
      chk("u2 scoreboard drained", 64'(q2.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/one_unit_mat_ser.md
Name: one_unit_mat_ser

Overview:
- Matrix-to-stream serializer on the read side of the 4x4 matrix datapath (e.g. behind the MUL2 squaring unit).
- Captures one 26-bit Q13 4x4 matrix in parallel through a valid/ready load handshake.
- Streams its 16 elements one per handshake to a narrow consumer (normalizer, memory writer), with row/column/last/tag sideband.
- Supports back-to-back matrices with zero bubble.

Parameters:
- W, 26, element width (signed Q13 fixed point).
- COL_MAJOR, 0, 0 = row-major emission order (11,12,13,14,21,...); 1 = column-major (11,21,31,41,12,...).
- STALL_W, 16, width of the saturating backpressure counter.

Ports:
- clk_ser  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld_valid  in  1  load request, matrix on ld_mat valid.
- ld_ready  out  1  block can accept a matrix this cycle.
- ld_mat  in  16*W  packed matrix; element (r,c), r,c=1..4, at bits [((r-1)*4+(c-1))*W +: W].
- ld_tag  in  2  matrix identifier (which of the four unit matrices), carried to output.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts element.
- out_data  out  W  current element, signed, unmodified.
- out_row  out  2  row index of current element, 0..3.
- out_col  out  2  column index of current element, 0..3.
- out_last  out  1  current element is the 16th of the matrix.
- out_tag  out  2  ld_tag of the matrix being streamed.
- busy  out  1  matrix held, stream not finished.
- stall_cnt  out  STALL_W  count of cycles with out_valid=1 and out_ready=0, saturating.
- stall_clr  in  1  synchronous clear of stall_cnt.

Behaviour:
- State machine: IDLE, STREAM.
- Reset (async, immediate): state=IDLE, element counter=0, out_valid=0, out_last=0, out_data=0, out_row=0, out_col=0, out_tag=0, busy=0, stall_cnt=0, capture register=0. An in-flight matrix is discarded with no partial output after reset release.
- ld_ready is combinational:
  - 1 in IDLE.
  - In STREAM, 1 only when out_valid & out_ready & out_last (last element leaving).
  - 0 otherwise.
- Load accept (ld_valid & ld_ready) at edge k:
  - ld_mat and ld_tag go into the capture register; counter=0; state=STREAM.
  - From cycle k+1: out_valid=1 with element 0. Latency is 1 cycle.
- Element advance: each out_valid & out_ready edge increments the counter.
- Output hold: while out_valid=1 and out_ready=0, out_data, out_row, out_col, out_last and out_tag hold stable.
- Emission order:
  - Counter i selects row-major (r=i/4, c=i%4) when COL_MAJOR=0.
  - Counter i selects column-major (c=i/4, r=i%4) when COL_MAJOR=1.
  - out_row/out_col always report the true matrix position, independent of order.
- out_last=1 only when i=15 and out_valid=1.
- End of matrix (element 15 accepted):
  - With a simultaneous load accept: capture the new matrix, counter=0, stay in STREAM. out_valid stays 1; the next cycle shows element 0 of the new matrix (no bubble).
  - Without one: state=IDLE, out_valid=0 next cycle.
- ld_valid while ld_ready=0 has no effect. The upstream holds ld_mat/ld_tag until accepted. The capture register never changes mid-stream.
- busy = (state==STREAM).
- stall_cnt:
  - Increments each cycle with out_valid & !out_ready.
  - Saturates at 2^STALL_W-1.
  - stall_clr forces 0 next edge and wins over a simultaneous increment.
- Arithmetic: none on data. Elements pass bit-exact, sign preserved. No rescaling; the upstream already applied the [38:13] Q13 extraction.
- out_data, out_row, out_col, out_last and out_tag are driven from registered state (capture register + counter), glitch-free.

Test Plan:
- Reset, then load matrix with element(r,c)=r*16+c, tag=2, out_ready=1 constantly. Required:
  - ld_ready=1 in idle.
  - out_valid rises exactly 1 cycle after accept.
  - 16 consecutive elements 17,18,19,20,33,...,68.
  - out_last only on 68; out_tag=2 throughout.
  - out_valid=0 the cycle after.
- COL_MAJOR=1, same matrix. Required: sequence 17,33,49,65,18,...,68, with out_row/out_col matching each value.
- Backpressure: toggle out_ready 1,0,0,1,... during streaming. Required:
  - No element dropped or duplicated.
  - Outputs stable during stalls.
  - stall_cnt equals the number of out_ready=0 cycles with out_valid=1.
  - stall_clr then returns stall_cnt to 0.
- Back-to-back: hold ld_valid high with matrix B (all elements -1 = 26'h3FFFFFF, tag=3) while matrix A streams. Required:
  - ld_ready=1 only in the out_last handshake cycle.
  - B element 0 (-1, sign intact) appears the very next cycle; no idle cycle.
- Reset mid-stream: assert rst_n=0 asynchronously after element 7. Required:
  - out_valid, busy and stall_cnt go 0 immediately, without waiting for a clock edge.
  - After release, ld_ready=1 and no stale elements are emitted.
  - A fresh load streams correctly from element 0.
- Saturation: STALL_W=4, hold out_ready=0 for 20 cycles. Required: stall_cnt stops at 15 and out_data stays at element 0.
